// File: rtl/ram_arb_pkg.sv
// Shared types and limits for the round-robin RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int STAT_WIDTH = 16;
    localparam int N_REQ_MIN  = 2;
    localparam int N_REQ_MAX  = 8;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offset 1..N_REQ so last_gnt itself is considered only after everyone else.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_gnt) + i) % N_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt[IDX_W'(cand)]    = 1'b1;
                gnt_idx              = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among N_REQ requesters.
// Optional per-requester grant counters when RAM_ARB_STATS_EN is defined.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int N_REQ      = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0]                     req_we,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [N_REQ-1:0]                     rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic [ADDR_WIDTH-1:0]                ram_addr,
    output logic [DATA_WIDTH-1:0]                ram_din,
    output logic                                 ram_we,
    input  logic [DATA_WIDTH-1:0]                ram_dout
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][STAT_WIDTH-1:0]     stat_grants
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("ram_arbiter: N_REQ out of range");
    end

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      last_gnt_q;
    logic [N_REQ-1:0]      gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  hs;

    logic                  cmd_we_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [IDX_W-1:0]      cmd_idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // The picker only grants valid requesters, so any grant in IDLE is a handshake.
    assign hs = (state_q == IDLE) && (|gnt);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) state_d = ISSUE;
            end
            ISSUE: begin
                ram_we  = cmd_we_q;
                state_d = cmd_we_q ? RESP : WAIT;
            end
            WAIT:    state_d = RESP;
            RESP: begin
                rsp_valid[cmd_idx_q] = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command registers drive the RAM directly, so the bus holds between commands.
    assign ram_addr  = cmd_addr_q;
    assign ram_din   = cmd_wdata_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= IDX_W'(N_REQ - 1);
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_idx_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                last_gnt_q  <= gnt_idx;
                cmd_idx_q   <= gnt_idx;
                cmd_we_q    <= req_we[gnt_idx];
                cmd_addr_q  <= req_addr[gnt_idx];
                cmd_wdata_q <= req_wdata[gnt_idx];
            end
            if (state_q == WAIT) rdata_q <= ram_dout;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_WIDTH-1:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (hs && gnt[i] && (stat_q[i] != {STAT_WIDTH{1'b1}}))
                    stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    assign stat_grants = stat_q;
`endif

endmodule
